// File: rtl/rns_result_collector.sv
// rns_result_collector
// Return path for the RNS add/sub/mul units. A small tag FIFO records the op
// code of every issued operation, and results are returned strictly in issue
// order through a single registered output stage with valid/ready handshake.
// Op code 3 ("zero") completes with result 0 and never waits on a unit.

module rns_result_collector #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [1:0]                   issue_sel,
  output logic                         issue_ready,
  input  logic [W-1:0]                 add_res,
  input  logic                         add_valid,
  output logic                         add_ack,
  input  logic [W-1:0]                 sub_res,
  input  logic                         sub_valid,
  output logic                         sub_ack,
  input  logic [W-1:0]                 mul_res,
  input  logic                         mul_valid,
  output logic                         mul_ack,
  output logic [W-1:0]                 res_data,
  output logic [1:0]                   res_sel,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] SEL_ADD  = 2'd0;
  localparam logic [1:0] SEL_SUB  = 2'd1;
  localparam logic [1:0] SEL_MUL  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  out_state_t        state_reg, state_next;
  logic [W-1:0]      res_data_reg, res_data_next;
  logic [1:0]        res_sel_reg, res_sel_next;

  // Tag storage is only a handful of 2-bit entries; the head is read
  // asynchronously so a ready head can pop in the cycle after its issue.
  logic [1:0]        tag_mem [DEPTH];
  logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]     count_reg;

  logic [1:0]        head;
  logic              fifo_empty;
  logic              push;
  logic              eligible;
  logic              pop;
  logic [W-1:0]      head_res;

  assign head        = tag_mem[rd_ptr_reg];
  assign fifo_empty  = (count_reg == '0);
  // Readiness depends only on the registered count: no bypass when full.
  assign issue_ready = (count_reg != CW'(DEPTH));
  assign push        = issue_valid && issue_ready && !rst;

  // Head eligibility: the matching unit must be valid, zero ops always are.
  always_comb begin
    eligible = 1'b0;
    head_res = '0;
    if (!fifo_empty) begin
      case (head)
        SEL_ADD:  begin eligible = add_valid; head_res = add_res; end
        SEL_SUB:  begin eligible = sub_valid; head_res = sub_res; end
        SEL_MUL:  begin eligible = mul_valid; head_res = mul_res; end
        default:  begin eligible = 1'b1;      head_res = '0;      end
      endcase
    end
  end

  // Gating with rst keeps every ack low while reset is asserted.
  assign pop     = eligible && ((state_reg == OUT_EMPTY) || res_ready) && !rst;
  assign add_ack = pop && (head == SEL_ADD);
  assign sub_ack = pop && (head == SEL_SUB);
  assign mul_ack = pop && (head == SEL_MUL);

  // Output stage next state: load on pop, drain when consumed, else hold.
  always_comb begin
    state_next    = state_reg;
    res_data_next = res_data_reg;
    res_sel_next  = res_sel_reg;
    if (pop) begin
      state_next    = OUT_FULL;
      res_data_next = head_res;
      res_sel_next  = head;
    end else if ((state_reg == OUT_FULL) && res_ready) begin
      state_next    = OUT_EMPTY;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= OUT_EMPTY;
      res_data_reg <= '0;
      res_sel_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      res_data_reg <= res_data_next;
      res_sel_reg  <= res_sel_next;
    end
  end

  // Tag write; contents need no reset because the count qualifies them.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= issue_sel;
    end
  end

  // FIFO pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign res_data  = res_data_reg;
  assign res_sel   = res_sel_reg;
  assign res_valid = (state_reg == OUT_FULL);
  assign pending   = count_reg;

endmodule

// File: tb/tb_rns_result_collector.sv
// Directed testbench for rns_result_collector (W=4, DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit later, well away from the next edge.

module tb_rns_result_collector;

  localparam int W     = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic [1:0]   issue_sel;
  logic         issue_ready;
  logic [W-1:0] add_res, sub_res, mul_res;
  logic         add_valid, sub_valid, mul_valid;
  logic         add_ack, sub_ack, mul_ack;
  logic [W-1:0] res_data;
  logic [1:0]   res_sel;
  logic         res_valid;
  logic         res_ready;
  logic [2:0]   pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rns_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_sel   (issue_sel),
    .issue_ready (issue_ready),
    .add_res     (add_res),
    .add_valid   (add_valid),
    .add_ack     (add_ack),
    .sub_res     (sub_res),
    .sub_valid   (sub_valid),
    .sub_ack     (sub_ack),
    .mul_res     (mul_res),
    .mul_valid   (mul_valid),
    .mul_ack     (mul_ack),
    .res_data    (res_data),
    .res_sel     (res_sel),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .pending     (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_acks(input string tag, input logic a, input logic s, input logic m);
    chk({tag, "_add_ack"}, 32'(add_ack), 32'(a));
    chk({tag, "_sub_ack"}, 32'(sub_ack), 32'(s));
    chk({tag, "_mul_ack"}, 32'(mul_ack), 32'(m));
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d, input logic [1:0] s);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'(v));
    chk({tag, "_res_data"},  32'(res_data),  32'(d));
    chk({tag, "_res_sel"},   32'(res_sel),   32'(s));
    $display("t=%0t %s: valid=%0d data=%0d sel=%0d pending=%0d", $time, tag, res_valid, res_data, res_sel, pending);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_sel = 2'd0; res_ready = 1'b1;
    add_res = '0; sub_res = '0; mul_res = '0;
    add_valid = 1'b0; sub_valid = 1'b0; mul_valid = 1'b0;

    // 1: reset
    step(); step();
    add_valid = 1'b1;
    #1;
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk_out("rst", 1'b0, 4'd0, 2'd0);
    chk_acks("rst", 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0; add_valid = 1'b0;

    // 2: in-order return with all units valid
    add_res = 4'd3; sub_res = 4'd5; mul_res = 4'd9;
    add_valid = 1'b1; sub_valid = 1'b1; mul_valid = 1'b1;
    issue_valid = 1'b1; issue_sel = 2'd0;
    step();                              // add pushed
    issue_sel = 2'd1; #1;
    chk_acks("ord1", 1'b1, 1'b0, 1'b0);
    step();                              // add popped, sub pushed
    issue_sel = 2'd2; #1;
    chk_out("ord_add", 1'b1, 4'd3, 2'd0);
    chk_acks("ord2", 1'b0, 1'b1, 1'b0);
    step();                              // sub popped, mul pushed
    issue_valid = 1'b0; #1;
    chk_out("ord_sub", 1'b1, 4'd5, 2'd1);
    chk_acks("ord3", 1'b0, 1'b0, 1'b1);
    step();                              // mul popped
    #1;
    chk_out("ord_mul", 1'b1, 4'd9, 2'd2);
    chk_acks("ord4", 1'b0, 1'b0, 1'b0);
    chk("ord_pending", 32'(pending), 32'd0);
    step();
    add_valid = 1'b0; sub_valid = 1'b0; mul_valid = 1'b0; #1;
    chk("ord_drain", 32'(res_valid), 32'd0);

    // 3: late add blocks a ready mul
    issue_valid = 1'b1; issue_sel = 2'd0;
    step();
    issue_sel = 2'd2;
    step();
    issue_valid = 1'b0; mul_res = 4'd7; mul_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_acks("blk_wait", 1'b0, 1'b0, 1'b0);
      chk("blk_wait_valid", 32'(res_valid), 32'd0);
      step();
    end
    add_res = 4'd2; add_valid = 1'b1; #1;
    chk_acks("blk_add", 1'b1, 1'b0, 1'b0);
    step();
    add_valid = 1'b0; #1;
    chk_out("blk_res_add", 1'b1, 4'd2, 2'd0);
    chk_acks("blk_mul", 1'b0, 1'b0, 1'b1);
    step();
    mul_valid = 1'b0; #1;
    chk_out("blk_res_mul", 1'b1, 4'd7, 2'd2);
    step(); #1;
    chk("blk_drain", 32'(res_valid), 32'd0);
    chk("blk_pending", 32'(pending), 32'd0);

    // 4: zero op under backpressure
    res_ready = 1'b0; issue_valid = 1'b1; issue_sel = 2'd3;
    step();
    issue_valid = 1'b0; #1;
    chk("zero_pending", 32'(pending), 32'd1);
    chk_acks("zero_pop", 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out("zero_hold", 1'b1, 4'd0, 2'd3);
      step();
    end
    res_ready = 1'b1; #1;
    chk_out("zero_last", 1'b1, 4'd0, 2'd3);
    step(); #1;
    chk("zero_drain", 32'(res_valid), 32'd0);

    // 5: tag FIFO full, dropped issue, no bypass on pop
    issue_valid = 1'b1; issue_sel = 2'd0;
    for (int i = 0; i < DEPTH; i++) step();
    #1;
    chk("full_pending", 32'(pending), 32'd4);
    chk("full_issue_ready", 32'(issue_ready), 32'd0);
    issue_sel = 2'd1;
    step(); #1;
    chk("full_drop_pending", 32'(pending), 32'd4);
    add_res = 4'd4; add_valid = 1'b1; #1;
    chk("full_nobypass_ready", 32'(issue_ready), 32'd0);
    chk_acks("full_pop", 1'b1, 1'b0, 1'b0);
    step();
    add_valid = 1'b0; issue_valid = 1'b0; #1;
    chk("full_after_pending", 32'(pending), 32'd3);
    chk("full_after_ready", 32'(issue_ready), 32'd1);
    chk_out("full_res", 1'b1, 4'd4, 2'd0);

    // 6: reset with 3 ops outstanding and output full
    rst = 1'b1; add_valid = 1'b1; #1;
    chk_acks("mrst_during", 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0; sub_valid = 1'b1; mul_valid = 1'b1; #1;
    chk("mrst_pending", 32'(pending), 32'd0);
    chk_out("mrst", 1'b0, 4'd0, 2'd0);
    chk_acks("mrst_after", 1'b0, 1'b0, 1'b0);
    step(); #1;
    chk_acks("mrst_after2", 1'b0, 1'b0, 1'b0);
    chk("mrst_valid2", 32'(res_valid), 32'd0);
    add_valid = 1'b0; sub_valid = 1'b0; mul_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
